// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and sequences instruction fetch.
// Each cycle it increments, holds, takes a relative branch through a
// programmable signed offset table, halts, or (with PC_SEQ_RAS_EN defined)
// calls/returns through a small return-address stack.
//
// Optional feature macro: PC_SEQ_RAS_EN (return-address stack, call/ret).
//
// Ports:
//   clk, reset (async, active-low)
//   start, halt_req, stall          - sequencing control
//   br_en, br_taken, br_idx         - relative branch request + table index
//   call_en, ret_en                 - call/return (stack build only)
//   lut_we, lut_waddr, lut_wdata    - offset-table write port
//   prog_ctr                        - registered fetch address
//   fetch_valid                     - prog_ctr is a real fetch this cycle
//   done                            - sequencer is halted
//   ras_err                         - sticky stack overflow/underflow
module pc_sequencer #(
  parameter int unsigned D         = 12,
  parameter int unsigned L         = 3,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         halt_req,
  input  logic         stall,
  input  logic         br_en,
  input  logic         br_taken,
  input  logic [L-1:0] br_idx,
  input  logic         call_en,
  input  logic         ret_en,
  input  logic         lut_we,
  input  logic [L-1:0] lut_waddr,
  input  logic [D-1:0] lut_wdata,
  output logic [D-1:0] prog_ctr,
  output logic         fetch_valid,
  output logic         done,
  output logic         ras_err
);

  localparam int unsigned LUT_N = 1 << L;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALTED} state_t;

  state_t       state, state_nxt;
  logic [D-1:0] pc_nxt;
  logic [D-1:0] lut [LUT_N];
  logic [D-1:0] pc_inc;
  logic [D-1:0] pc_br;

  // Signed offsets wrap naturally in D-bit two's-complement addition.
  assign pc_inc = prog_ctr + D'(1);
  assign pc_br  = prog_ctr + lut[br_idx];

  assign fetch_valid = (state == RUN) && !stall;
  assign done        = (state == HALTED);

`ifdef PC_SEQ_RAS_EN
  localparam int unsigned SPW  = $clog2(RAS_DEPTH + 1);
  localparam int unsigned IDXW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [D-1:0]   ras [RAS_DEPTH];
  logic [SPW-1:0] sp;
  logic           push, pop, err_set;
  logic           ras_full, ras_empty;
  logic [D-1:0]   ras_top;

  assign ras_full  = (sp == SPW'(RAS_DEPTH));
  assign ras_empty = (sp == '0);
  assign ras_top   = ras[IDXW'(sp - SPW'(1))];
`else
  logic unused_ras;
  assign unused_ras = ^{call_en, ret_en, 1'(RAS_DEPTH)};
  assign ras_err    = 1'b0;
`endif

  // Next-state and next-PC selection.
  always_comb begin
    state_nxt = state;
    pc_nxt    = prog_ctr;
`ifdef PC_SEQ_RAS_EN
    push      = 1'b0;
    pop       = 1'b0;
    err_set   = 1'b0;
`endif
    unique case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
        end
      end
      RUN: begin
        if (halt_req) begin
          state_nxt = HALTED;
        end else if (!stall) begin
`ifdef PC_SEQ_RAS_EN
          if (ret_en) begin
            // Underflow: flag it and keep fetching sequentially.
            if (ras_empty) begin
              err_set = 1'b1;
              pc_nxt  = pc_inc;
            end else begin
              pop       = 1'b1;
              pc_nxt    = ras_top;
              state_nxt = FLUSH;
            end
          end else if (call_en) begin
            // Overflow drops the return address but still jumps.
            if (ras_full) err_set = 1'b1;
            else          push    = 1'b1;
            pc_nxt    = pc_br;
            state_nxt = FLUSH;
          end else
`endif
          if (br_en && br_taken) begin
            pc_nxt    = pc_br;
            state_nxt = FLUSH;
          end else begin
            pc_nxt = pc_inc;
          end
        end
      end
      FLUSH: begin
        state_nxt = halt_req ? HALTED : RUN;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and program counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      prog_ctr <= '0;
    end else begin
      state    <= state_nxt;
      prog_ctr <= pc_nxt;
    end
  end

  // Offset table; a same-cycle read of the written entry sees the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lut <= '{default: '0};
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

`ifdef PC_SEQ_RAS_EN
  // Return-address stack and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ras     <= '{default: '0};
      sp      <= '0;
      ras_err <= 1'b0;
    end else begin
      if (push) begin
        ras[IDXW'(sp)] <= pc_inc;
        sp             <= sp + SPW'(1);
      end else if (pop) begin
        sp <= sp - SPW'(1);
      end
      if (err_set) ras_err <= 1'b1;
    end
  end
`endif

endmodule
